// File: rtl/camera_buffer_pkg.sv
// Shared types and constants for the camera buffer download path.
package camera_buffer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } dl_state_t;

    localparam int BYTE_W      = 8;
    localparam int PCT_MAX     = 10;

    // Fill thresholds (tens of percent) the camera control logic reacts to.
    localparam int PCT_STANDBY = 8;
    localparam int PCT_SWITCH  = 9;
    localparam int PCT_FLUSH   = 5;

    // Fill level in tens of percent: floor(cnt*10 / 2**aw). Exact, never exceeds PCT_MAX.
    function automatic logic [3:0] pct_of(input logic [31:0] cnt, input int aw);
        logic [31:0] scaled;
        scaled = (cnt * 32'd10) >> aw;
        return scaled[3:0];
    endfunction

endpackage

// File: rtl/camera_buffer_download_req_sync.sv
// Multi-flop synchroniser for asynchronous level inputs from the microcontroller PIO.
module req_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the raw level through STAGES flops; the last stage is safe to use.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ff <= '0;
        else          ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/camera_buffer_download.sv
// Camera byte FIFO with fill-level reporting and a 4-phase req/ack byte download port.
module camera_buffer_download
    import camera_buffer_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fill_en,
    input  logic              cam_valid,
    input  logic [BYTE_W-1:0] cam_data,
    input  logic              flush,
    input  logic              dl_req,
    output logic              dl_ack,
    output logic [BYTE_W-1:0] cur_byte,
    output logic              dl_empty,
    output logic [ADDR_W:0]   count,
    output logic [3:0]        percent,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              req_s, wr_acc, rd_acc;
    logic              ack_nxt, dle_nxt;
    logic [BYTE_W-1:0] byte_nxt;
    dl_state_t         state, state_nxt;

    req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (dl_req),
        .q       (req_s)
    );

    // full is the pre-edge value, so a write into a full buffer drops even if a read frees a slot.
    assign wr_acc = fill_en & cam_valid & ~full & ~flush;

    // Download FSM: one byte per req/ack cycle; an empty buffer still acks, flagged by dl_empty.
    always_comb begin
        state_nxt = state;
        ack_nxt   = dl_ack;
        dle_nxt   = dl_empty;
        byte_nxt  = cur_byte;
        rd_acc    = 1'b0;
        case (state)
            IDLE: if (req_s) begin
                state_nxt = ACK;
                ack_nxt   = 1'b1;
                if (!empty && !flush) begin
                    rd_acc   = 1'b1;
                    byte_nxt = mem[rd_ptr];
                    dle_nxt  = 1'b0;
                end else begin
                    byte_nxt = '0;
                    dle_nxt  = 1'b1;
                end
            end
            ACK: if (!req_s) begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
                dle_nxt   = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next occupancy; flush wins over any concurrent write or read.
    always_comb begin
        count_nxt = count;
        if (flush)                 count_nxt = '0;
        else if (wr_acc & ~rd_acc) count_nxt = count + (ADDR_W+1)'(1);
        else if (rd_acc & ~wr_acc) count_nxt = count - (ADDR_W+1)'(1);
    end

    // Handshake state and presented byte; flush leaves an in-flight ack untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            dl_ack   <= 1'b0;
            dl_empty <= 1'b0;
            cur_byte <= '0;
        end else begin
            state    <= state_nxt;
            dl_ack   <= ack_nxt;
            dl_empty <= dle_nxt;
            cur_byte <= byte_nxt;
        end
    end

    // Pointers, occupancy and status flags, all registered from next-count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            percent  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
                if (fill_en & cam_valid & full) overflow <= 1'b1;
            end
            count   <= count_nxt;
            percent <= pct_of(32'(count_nxt), ADDR_W);
            full    <= (count_nxt == DEPTH_C);
            empty   <= (count_nxt == '0);
        end
    end

    // Byte storage; no reset needed since reads are gated by occupancy.
    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_ptr] <= cam_data;
    end

endmodule

// File: tb/tb_camera_buffer_download.sv
// Directed bench for camera_buffer_download with a queue-based reference model.
module tb_camera_buffer_download;
    import camera_buffer_pkg::*;

    localparam int AW    = 6;
    localparam int SS    = 2;
    localparam int DEPTH = 64;

    logic       clock, reset_n, fill_en, cam_valid, flush, dl_req;
    logic [7:0] cam_data;
    logic       dl_ack, dl_empty, full, empty, overflow;
    logic [7:0] cur_byte;
    logic [AW:0] count;
    logic [3:0] percent;

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    camera_buffer_download #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset_n(reset_n), .fill_en(fill_en), .cam_valid(cam_valid),
        .cam_data(cam_data), .flush(flush), .dl_req(dl_req), .dl_ack(dl_ack),
        .cur_byte(cur_byte), .dl_empty(dl_empty), .count(count), .percent(percent),
        .full(full), .empty(empty), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, request seen SS clocks late, one byte per request.
    logic [7:0] mq[$];
    bit         m_ovf, m_busy, m_ack, m_dle, m_reqs, m_wfull, m_wempty;
    logic [7:0] m_byte;
    bit [SS-1:0] m_req;

    // Model update on each active edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf = 0; m_busy = 0; m_ack = 0; m_dle = 0; m_byte = 8'h00; m_req = '0;
        end else begin
            m_reqs   = m_req[SS-1];
            m_req    = {m_req[SS-2:0], dl_req};
            m_wfull  = (mq.size() == DEPTH);
            m_wempty = (mq.size() == 0);
            if (!m_busy && m_reqs) begin
                m_busy = 1; m_ack = 1;
                if (!m_wempty && !flush) begin
                    m_byte = mq.pop_front(); m_dle = 0;
                end else begin
                    m_byte = 8'h00; m_dle = 1;
                end
            end else if (m_busy && !m_reqs) begin
                m_busy = 0; m_ack = 0; m_dle = 0;
            end
            if (flush) begin
                mq.delete(); m_ovf = 0;
            end else if (fill_en && cam_valid) begin
                if (m_wfull) m_ovf = 1;
                else mq.push_back(cam_data);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (chk_on && reset_n) begin
            chk("m_count",    count,    mq.size());
            chk("m_percent",  percent,  (mq.size() * 10) / DEPTH);
            chk("m_full",     full,     mq.size() == DEPTH);
            chk("m_empty",    empty,    mq.size() == 0);
            chk("m_overflow", overflow, m_ovf);
            chk("m_dl_ack",   dl_ack,   m_ack);
            chk("m_dl_empty", dl_empty, m_dle);
            chk("m_cur_byte", cur_byte, m_byte);
        end
    end

    task automatic wr(input logic [7:0] b);
        fill_en = 1; cam_valid = 1; cam_data = b;
        @(negedge clock);
        cam_valid = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        @(negedge clock);
        flush = 0;
    endtask

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        while (dl_ack !== lvl && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (dl_ack !== lvl) chk("ack_timeout", dl_ack, lvl);
    endtask

    task automatic download(output logic [7:0] b, output logic e);
        int n;
        dl_req = 1;
        wait_ack(1'b1, n);
        b = cur_byte; e = dl_empty;
        dl_req = 0;
        wait_ack(1'b0, n);
    endtask

    initial begin
        logic [7:0] b;
        logic       e;
        int         n;
        int         pts [6] = '{51, 52, 57, 58, 63, 64};
        int         pexp[6] = '{7, 8, 8, 9, 9, 10};

        fill_en = 0; cam_valid = 0; cam_data = 0; flush = 0; dl_req = 0;
        reset_n = 0;
        repeat (3) @(negedge clock);
        chk("rst_count", count, 0);     chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);       chk("rst_percent", percent, 0);
        chk("rst_ovf", overflow, 0);    chk("rst_ack", dl_ack, 0);
        chk("rst_dle", dl_empty, 0);    chk("rst_byte", cur_byte, 0);
        reset_n = 1;
        chk_on  = 1;
        @(negedge clock);

        // Three bytes in, three out in order.
        wr(8'hA1); wr(8'hB2); wr(8'hC3);
        chk("w3_count", count, 3); chk("w3_percent", percent, 0); chk("w3_empty", empty, 0);
        download(b, e); chk("rd_A1", b, 8'hA1); chk("rd_A1_dle", e, 0);
        download(b, e); chk("rd_B2", b, 8'hB2);
        download(b, e); chk("rd_C3", b, 8'hC3);
        chk("rd3_count", count, 0); chk("rd3_empty", empty, 1);

        // Fill to full checking percent boundaries, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            wr(8'(i));
            for (int k = 0; k < 6; k++)
                if (i + 1 == pts[k]) chk($sformatf("pct_at_%0d", pts[k]), percent, pexp[k]);
        end
        chk("full_flag", full, 1);
        wr(8'hEE);
        chk("ovf_flag", overflow, 1); chk("ovf_count", count, 64);
        for (int i = 0; i < DEPTH; i++) begin
            download(b, e);
            chk($sformatf("drain_%0d", i), b, i);
        end
        chk("drain_empty", empty, 1);
        for (int i = 0; i < 10; i++) wr(8'(8'h80 + i));
        for (int i = 0; i < 10; i++) begin
            download(b, e);
            chk($sformatf("wrap_%0d", i), b, 8'h80 + i);
        end

        // Write and read on the same edge at count 5.
        do_flush();
        for (int i = 1; i <= 5; i++) wr(8'(i));
        dl_req = 1;
        @(negedge clock); @(negedge clock);
        cam_valid = 1; cam_data = 8'h06;
        @(negedge clock);
        cam_valid = 0;
        chk("rw_ack", dl_ack, 1); chk("rw_count", count, 5); chk("rw_byte", cur_byte, 1);
        dl_req = 0; wait_ack(1'b0, n);
        for (int i = 2; i <= 6; i++) begin
            download(b, e);
            chk($sformatf("rw_order_%0d", i), b, i);
        end

        // Write and read together at full: write dropped.
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        dl_req = 1;
        @(negedge clock); @(negedge clock);
        cam_valid = 1; cam_data = 8'hFF;
        @(negedge clock);
        cam_valid = 0;
        chk("fullrw_count", count, 63); chk("fullrw_ovf", overflow, 1);
        dl_req = 0; wait_ack(1'b0, n);

        // Request on empty buffer: latency, empty flag, no further consumption.
        do_flush();
        chk("fl_count", count, 0);
        dl_req = 1;
        wait_ack(1'b1, n);
        chk("latency", n, SS + 1); chk("emp_dle", dl_empty, 1); chk("emp_byte", cur_byte, 0);
        repeat (20) @(negedge clock);
        chk("emp_hold_ack", dl_ack, 1); chk("emp_hold_count", count, 0);
        dl_req = 0; wait_ack(1'b0, n);
        wr(8'h11); wr(8'h22);
        dl_req = 1;
        wait_ack(1'b1, n);
        chk("hold_byte", cur_byte, 8'h11);
        repeat (20) @(negedge clock);
        chk("hold_count", count, 1);
        dl_req = 0; wait_ack(1'b0, n);
        download(b, e); chk("hold_next", b, 8'h22);

        // Flush during ACK.
        do_flush();
        for (int i = 0; i < 30; i++) wr(8'(8'h40 + i));
        dl_req = 1;
        wait_ack(1'b1, n);
        chk("fa_count_pre", count, 29);
        flush = 1;
        @(negedge clock);
        flush = 0;
        chk("fa_count", count, 0); chk("fa_percent", percent, 0); chk("fa_ack", dl_ack, 1);
        chk("fa_byte", cur_byte, 8'h40);
        dl_req = 0; wait_ack(1'b0, n);
        chk("fa_dle_clr", dl_empty, 0);
        download(b, e); chk("fa_next_dle", e, 1); chk("fa_next_byte", b, 0);

        // Reset mid-handshake drops ack immediately.
        wr(8'h5A);
        dl_req = 1;
        wait_ack(1'b1, n);
        #2 reset_n = 0;
        #1 chk("rst_mid_ack", dl_ack, 0);
        dl_req = 0;
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        chk("rst_mid_count", count, 0);
        repeat (4) @(negedge clock);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
